// File: rtl/link_tx_scheduler.sv
// Byte-stream scheduler for the opponent link: arbitrates START/SEED/DIR/heartbeat
// frames onto one valid/ready transmitter and supervises opponent liveness.
module link_tx_scheduler #(
    parameter int HB_PERIOD      = 750000,
    parameter int TIMEOUT_CYCLES = 7500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link_en,
    input  logic       start_req,
    input  logic       seed_req,
    input  logic [5:0] seed_x,
    input  logic [5:0] seed_y,
    input  logic       dir_req,
    input  logic [1:0] dir,
    input  logic       rx_alive,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       con_error
);

    localparam int HB_W = $clog2(HB_PERIOD);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_PERIOD - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      last_q, last_d;
    logic [7:0]      frame0_q, frame0_d;
    logic [7:0]      frame1_q, frame1_d;
    logic [7:0]      frame2_q, frame2_d;
    logic            start_pend_q, start_pend_d;
    logic            seed_pend_q, seed_pend_d;
    logic            dir_pend_q, dir_pend_d;
    logic            hb_pend_q, hb_pend_d;
    logic [5:0]      seed_x_q, seed_x_d;
    logic [5:0]      seed_y_q, seed_y_d;
    logic [1:0]      dir_pay_q, dir_pay_d;
    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            con_error_q, con_error_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            busy_q, busy_d;

    logic            hs_s;
    logic            any_pend_s;
    logic            hb_fire_s;
    logic            grant_start_s, grant_seed_s, grant_dir_s, grant_hb_s;

    function automatic logic [7:0] frame_byte(input logic [1:0] i, input logic [7:0] b0,
                                              input logic [7:0] b1, input logic [7:0] b2);
        case (i)
            2'd0:    frame_byte = b0;
            2'd1:    frame_byte = b1;
            2'd2:    frame_byte = b2;
            default: frame_byte = 8'h00;
        endcase
    endfunction

    assign hs_s       = tx_valid_q & tx_ready;
    assign any_pend_s = start_pend_q | seed_pend_q | dir_pend_q | hb_pend_q;

    // Heartbeat idle counter and opponent-silence supervision
    always_comb begin
        hb_cnt_d    = hb_cnt_q;
        hb_fire_s   = 1'b0;
        to_cnt_d    = to_cnt_q;
        con_error_d = con_error_q;
        if (!link_en || hs_s) begin
            hb_cnt_d = '0;
        end else if (state_q == ST_IDLE && !any_pend_s) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_d  = '0;
                hb_fire_s = 1'b1;
            end else begin
                hb_cnt_d = hb_cnt_q + HB_W'(1);
            end
        end else begin
            hb_cnt_d = hb_cnt_q;
        end
        // rx_alive beats a coincident saturation, so the flag only rises when truly silent
        if (!link_en) begin
            to_cnt_d    = '0;
            con_error_d = 1'b0;
        end else if (rx_alive) begin
            to_cnt_d    = '0;
            con_error_d = con_error_q;
        end else begin
            if (to_cnt_q != TO_MAX) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_d = to_cnt_q;
            end
            con_error_d = con_error_q | (to_cnt_d == TO_MAX);
        end
    end

    // Frame FSM: priority grant in IDLE, byte walk in SEND
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        last_d        = last_q;
        frame0_d      = frame0_q;
        frame1_d      = frame1_q;
        frame2_d      = frame2_q;
        grant_start_s = 1'b0;
        grant_seed_s  = 1'b0;
        grant_dir_s   = 1'b0;
        grant_hb_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (link_en && any_pend_s) begin
                    state_d = ST_SEND;
                    idx_d   = 2'd0;
                    if (start_pend_q) begin
                        grant_start_s = 1'b1;
                        frame0_d      = 8'hA4;
                        last_d        = 2'd0;
                    end else if (seed_pend_q) begin
                        grant_seed_s = 1'b1;
                        frame0_d     = 8'hA8;
                        frame1_d     = {2'b00, seed_x_q};
                        frame2_d     = {2'b00, seed_y_q};
                        last_d       = 2'd2;
                    end else if (dir_pend_q) begin
                        grant_dir_s = 1'b1;
                        frame0_d    = {6'b101011, dir_pay_q};
                        last_d      = 2'd0;
                    end else begin
                        grant_hb_s = 1'b1;
                        frame0_d   = 8'hA0;
                        last_d     = 2'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (hs_s) begin
                    if (idx_q == last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        tx_valid_d = (state_d == ST_SEND);
        busy_d     = (state_d == ST_SEND);
        if (tx_valid_d) begin
            tx_data_d = frame_byte(idx_d, frame0_d, frame1_d, frame2_d);
        end else begin
            tx_data_d = 8'h00;
        end
    end

    // Request capture: a fresh pulse re-arms even on the edge its type is granted
    always_comb begin
        start_pend_d = start_pend_q;
        seed_pend_d  = seed_pend_q;
        dir_pend_d   = dir_pend_q;
        hb_pend_d    = hb_pend_q;
        seed_x_d     = seed_x_q;
        seed_y_d     = seed_y_q;
        dir_pay_d    = dir_pay_q;
        if (!link_en) begin
            start_pend_d = 1'b0;
            seed_pend_d  = 1'b0;
            dir_pend_d   = 1'b0;
            hb_pend_d    = 1'b0;
        end else begin
            start_pend_d = (start_pend_q & ~grant_start_s) | start_req;
            seed_pend_d  = (seed_pend_q & ~grant_seed_s) | seed_req;
            dir_pend_d   = (dir_pend_q & ~grant_dir_s) | dir_req;
            hb_pend_d    = (hb_pend_q & ~grant_hb_s) | hb_fire_s;
            if (seed_req) begin
                seed_x_d = seed_x;
                seed_y_d = seed_y;
            end else begin
                seed_x_d = seed_x_q;
                seed_y_d = seed_y_q;
            end
            if (dir_req) begin
                dir_pay_d = dir;
            end else begin
                dir_pay_d = dir_pay_q;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            last_q       <= 2'd0;
            frame0_q     <= 8'h00;
            frame1_q     <= 8'h00;
            frame2_q     <= 8'h00;
            start_pend_q <= 1'b0;
            seed_pend_q  <= 1'b0;
            dir_pend_q   <= 1'b0;
            hb_pend_q    <= 1'b0;
            seed_x_q     <= 6'd0;
            seed_y_q     <= 6'd0;
            dir_pay_q    <= 2'd0;
            hb_cnt_q     <= '0;
            to_cnt_q     <= '0;
            con_error_q  <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            frame0_q     <= frame0_d;
            frame1_q     <= frame1_d;
            frame2_q     <= frame2_d;
            start_pend_q <= start_pend_d;
            seed_pend_q  <= seed_pend_d;
            dir_pend_q   <= dir_pend_d;
            hb_pend_q    <= hb_pend_d;
            seed_x_q     <= seed_x_d;
            seed_y_q     <= seed_y_d;
            dir_pay_q    <= dir_pay_d;
            hb_cnt_q     <= hb_cnt_d;
            to_cnt_q     <= to_cnt_d;
            con_error_q  <= con_error_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign con_error = con_error_q;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Bench for link_tx_scheduler: queue-based frame model checked every cycle,
// directed scenarios with literal byte/timing expectations, then random traffic.
module tb_link_tx_scheduler;

    localparam int HB = 16;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       link_en = 1'b0;
    logic       start_req = 1'b0;
    logic       seed_req = 1'b0;
    logic [5:0] seed_x = 6'd0;
    logic [5:0] seed_y = 6'd0;
    logic       dir_req = 1'b0;
    logic [1:0] dir = 2'd0;
    logic       rx_alive = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       con_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    link_tx_scheduler #(.HB_PERIOD(HB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .link_en(link_en),
        .start_req(start_req), .seed_req(seed_req), .seed_x(seed_x), .seed_y(seed_y),
        .dir_req(dir_req), .dir(dir), .rx_alive(rx_alive),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .con_error(con_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: pending flags, a byte queue for the frame on the wire, integer counters
    bit         m_live = 1'b0;
    bit         m_busy, m_err, m_hs, m_any, m_fire;
    bit         p_start, p_seed, p_dir, p_hb;
    logic [5:0] m_x, m_y;
    logic [1:0] m_dir;
    logic [7:0] m_frame[$];
    int         m_idle, m_silent;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            m_live = 1'b1; m_busy = 1'b0; m_err = 1'b0;
            m_frame.delete();
            p_start = 1'b0; p_seed = 1'b0; p_dir = 1'b0; p_hb = 1'b0;
            m_idle = 0; m_silent = 0;
        end else if (m_live) begin
            m_hs   = m_busy && tx_ready;
            m_any  = p_start || p_seed || p_dir || p_hb;
            m_fire = 1'b0;
            if (!link_en || m_hs) m_idle = 0;
            else if (!m_busy && !m_any) begin
                if (m_idle == HB - 1) begin m_idle = 0; m_fire = 1'b1; end
                else m_idle = m_idle + 1;
            end
            if (m_hs) begin
                void'(m_frame.pop_front());
                if (m_frame.size() == 0) m_busy = 1'b0;
            end else if (!m_busy && link_en && m_any) begin
                m_busy = 1'b1;
                if (p_start) begin m_frame.push_back(8'hA4); p_start = 1'b0; end
                else if (p_seed) begin
                    m_frame.push_back(8'hA8);
                    m_frame.push_back(8'(m_x));
                    m_frame.push_back(8'(m_y));
                    p_seed = 1'b0;
                end else if (p_dir) begin m_frame.push_back(8'hAC + 8'(m_dir)); p_dir = 1'b0; end
                else begin m_frame.push_back(8'hA0); p_hb = 1'b0; end
            end
            if (!link_en) begin
                p_start = 1'b0; p_seed = 1'b0; p_dir = 1'b0; p_hb = 1'b0;
            end else begin
                if (start_req) p_start = 1'b1;
                if (seed_req) begin p_seed = 1'b1; m_x = seed_x; m_y = seed_y; end
                if (dir_req) begin p_dir = 1'b1; m_dir = dir; end
                if (m_fire) p_hb = 1'b1;
            end
            if (!link_en) begin m_silent = 0; m_err = 1'b0; end
            else if (rx_alive) m_silent = 0;
            else begin
                if (m_silent < TO) m_silent = m_silent + 1;
                if (m_silent == TO) m_err = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of accepted bytes
    logic [7:0] log_b[$];
    int         log_t[$];

    always @(negedge clk) begin
        if (m_live) begin
            check("tx_valid", tx_valid, m_busy);
            check("busy", busy, m_busy);
            check("con_error", con_error, m_err);
            if (m_busy) check("tx_data", tx_data, m_frame[0]);
            if (tx_valid === 1'b1 && tx_ready) begin
                log_b.push_back(tx_data);
                log_t.push_back(cyc);
            end
        end
    end

    // rx_alive source: 1 = every 30 cycles, 2 = random, otherwise silent
    int rx_mode = 0;
    int rx_cnt = 0;
    int rx_edge = 0;

    always @(posedge clk) begin
        #1;
        case (rx_mode)
            1: begin rx_cnt++; rx_alive = (rx_cnt % 30 == 0); end
            2: rx_alive = ($urandom_range(49) == 0);
            default: rx_alive = 1'b0;
        endcase
        if (rx_alive) rx_edge = cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_b.delete();
        log_t.delete();
    endtask

    task automatic expect_log(input string name, input int n, input logic [63:0] bytes);
        check({name, "_len"}, log_b.size(), n);
        for (int i = 0; i < n && i < log_b.size(); i++)
            check(name, log_b[i], bytes[8*(n-1-i) +: 8]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int  req_t;
    int  t0;
    bit  found;

    initial begin
        rst = 1'b0; link_en = 1'b1; tx_ready = 1'b1;
        repeat (2) tick();
        check("rst_valid", tx_valid, 1'b0);
        check("rst_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_err", con_error, 1'b0);
        rst = 1'b1; rx_mode = 1;
        tick();

        // SEED 17/42 with latency pinned
        clear_log();
        seed_x = 6'd17; seed_y = 6'd42; seed_req = 1'b1;
        tick(); seed_req = 1'b0; req_t = cyc;
        repeat (6) tick();
        expect_log("seed", 3, {8'hA8, 8'h11, 8'h2A});
        if (log_t.size() == 3) begin
            check("seed_latency", log_t[0] - req_t, 1);
            check("seed_b2b", log_t[2] - log_t[0], 2);
        end

        // Simultaneous requests: priority order and one idle gap between frames
        clear_log();
        start_req = 1'b1; seed_req = 1'b1; seed_x = 6'd1; seed_y = 6'd2;
        dir_req = 1'b1; dir = 2'b10;
        tick(); start_req = 1'b0; seed_req = 1'b0; dir_req = 1'b0;
        repeat (12) tick();
        expect_log("simul", 5, {8'hA4, 8'hA8, 8'h01, 8'h02, 8'hAE});
        if (log_t.size() == 5) begin
            check("gap0", log_t[1] - log_t[0], 2);
            check("gap1", log_t[2] - log_t[1], 1);
            check("gap2", log_t[3] - log_t[2], 1);
            check("gap3", log_t[4] - log_t[3], 2);
        end

        // Backpressure on SEED byte 1 with a DIR request in the stall window
        clear_log();
        seed_x = 6'd17; seed_y = 6'd42; seed_req = 1'b1;
        tick(); seed_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (tx_valid && tx_data == 8'h11) found = 1'b1;
        end
        check("stall_reach", found, 1'b1);
        tx_ready = 1'b0; dir = 2'd1; dir_req = 1'b1;
        tick(); dir_req = 1'b0;
        check("stall_data", tx_data, 8'h11);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_data", tx_data, 8'h11);
            check("stall_valid", tx_valid, 1'b1);
        end
        tx_ready = 1'b1;
        repeat (8) tick();
        expect_log("stall", 4, {8'hA8, 8'h11, 8'h2A, 8'hAD});

        // Heartbeats on a quiet link
        clear_log();
        repeat (100) tick();
        check("hb_count", log_b.size() >= 4, 1'b1);
        for (int i = 0; i < log_b.size(); i++) check("hb_byte", log_b[i], 8'hA0);
        for (int i = 1; i < log_t.size(); i++) check("hb_period", log_t[i] - log_t[i-1], 18);

        // Opponent goes silent: con_error exactly TO cycles after the last rx_alive
        rx_mode = 0;
        found = 1'b0; t0 = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (con_error) begin found = 1'b1; t0 = cyc; end
        end
        check("timeout_seen", found, 1'b1);
        check("timeout_delay", t0 - rx_edge, TO);

        // link_en pulse clears con_error and drops a pending DIR
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) found = 1'b1;
        end
        check("hb_sync", found, 1'b1);
        tick();
        clear_log();
        tx_ready = 1'b0; seed_x = 6'd5; seed_y = 6'd9; seed_req = 1'b1;
        tick(); seed_req = 1'b0; dir = 2'd3; dir_req = 1'b1;
        tick(); dir_req = 1'b0;
        tick(); link_en = 1'b0;
        tick(); link_en = 1'b1;
        check("drop_err", con_error, 1'b0);
        tx_ready = 1'b1;
        repeat (8) tick();
        expect_log("drop", 3, {8'hA8, 8'h05, 8'h09});
        clear_log();
        link_en = 1'b0; dir = 2'd1; dir_req = 1'b1;
        tick(); dir_req = 1'b0;
        repeat (8) tick();
        check("dir_when_off", log_b.size(), 0);
        link_en = 1'b1; rx_mode = 1;

        // Reset during SEED byte 2
        seed_x = 6'd3; seed_y = 6'd9; seed_req = 1'b1;
        tick(); seed_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (tx_valid && tx_data == 8'h09) found = 1'b1;
        end
        check("byte2_reach", found, 1'b1);
        tx_ready = 1'b0; rst = 1'b0;
        tick();
        check("midrst_valid", tx_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_err", con_error, 1'b0);
        rst = 1'b1; tx_ready = 1'b1;
        clear_log();
        repeat (10) tick();
        check("midrst_residual", log_b.size(), 0);

        // Random traffic in a dense and a sparse phase
        rx_mode = 2;
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                int dens;
                dens = (ph == 0) ? 3 : 25;
                start_req = ($urandom_range(dens * 3) == 0);
                seed_req  = ($urandom_range(dens) == 0);
                dir_req   = ($urandom_range(dens) == 0);
                seed_x    = 6'($urandom);
                seed_y    = 6'($urandom);
                dir       = 2'($urandom);
                tx_ready  = ($urandom_range(3) != 0);
                link_en   = ($urandom_range(200) != 0);
                rst       = ($urandom_range(700) != 0);
                tick();
            end
        end
        start_req = 1'b0; seed_req = 1'b0; dir_req = 1'b0; rst = 1'b1; link_en = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
